// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter and its busy scoreboard.
package rf_arb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic                valid;
        reg_addr_t           rd;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WB0  = 2'd1,
        GRANT_WB1  = 2'd2
    } grant_e;

    // True when probe names a real register (not x0) equal to target.
    function automatic logic addr_hit(input reg_addr_t probe, input reg_addr_t target);
        return (probe != '0) && (probe == target);
    endfunction

endpackage

// File: rtl/rf_arb_pkg_scoreboard.sv
// Companion constants for the busy scoreboard; the scoreboard logic itself lives in rf_scoreboard.sv.
package rf_arb_scoreboard_pkg;
    localparam int SB_LOOKUP_PORTS = 3;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for destinations owned by the long-latency unit.
// A set and a clear of the same register in one cycle leaves it busy; x0 is never busy.
module rf_scoreboard
    import rf_arb_pkg::*;
(
    input  logic                clk,
    input  logic                areset,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_addr,
    input  logic [REG_AW-1:0]   look_a,
    input  logic [REG_AW-1:0]   look_b,
    input  logic [REG_AW-1:0]   iss_addr,
    output logic                busy_a,
    output logic                busy_b,
    output logic                iss_busy
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    assign set_vec[0] = 1'b0;
    assign clr_vec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_decode
            assign set_vec[gi] = set_en && (set_addr == REG_AW'(gi));
            assign clr_vec[gi] = clr_en && (clr_addr == REG_AW'(gi));
        end
    endgenerate

    // Set is applied after clear so a same-cycle collision keeps the bit.
    assign busy_next = (busy_reg & ~clr_vec) | set_vec;

    always_ff @(posedge clk) begin
        if (!areset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_a   = busy_reg[look_a];
    assign busy_b   = busy_reg[look_b];
    assign iss_busy = busy_reg[iss_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the register file write port with starvation guard and RAW hazard detection.
// Optional RF_ARB_BYPASS_EN adds forwarding of the in-flight write and removes it from the hazard term.
module regfile_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                wb0_valid,
    output logic                wb0_ready,
    input  logic [REG_AW-1:0]   wb0_rd,
    input  logic [XLEN-1:0]     wb0_data,
    input  logic                wb1_valid,
    output logic                wb1_ready,
    input  logic [REG_AW-1:0]   wb1_rd,
    input  logic [XLEN-1:0]     wb1_data,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_rd,
    output logic                iss_ready,
    input  logic [REG_AW-1:0]   rs1,
    input  logic [REG_AW-1:0]   rs2,
    output logic                hazard,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]     rf_wdata
`ifdef RF_ARB_BYPASS_EN
    ,
    output logic                byp1_hit,
    output logic                byp2_hit,
    output logic [XLEN-1:0]     byp_data
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic              starve_reg;
    logic              starve_next;
    logic [3:0]        starve_cnt_reg;
    logic [3:0]        starve_cnt_next;
    logic              we_reg;
    logic [REG_AW-1:0] waddr_reg;
    logic [XLEN-1:0]   wdata_reg;
    grant_e            grant;
    logic              busy_1;
    logic              busy_2;
    logic              iss_busy;

    // Ready depends only on the starve flag and the opposing valid, never on data.
    always_comb begin
        wb0_ready = 1'b1;
        wb1_ready = !wb0_valid;
        if (starve_reg) begin
            wb1_ready = 1'b1;
            wb0_ready = !wb1_valid;
        end
    end

    always_comb begin
        grant = GRANT_NONE;
        if (wb0_valid && wb0_ready) begin
            grant = GRANT_WB0;
        end else if (wb1_valid && wb1_ready) begin
            grant = GRANT_WB1;
        end
    end

    // Starve is raised on the same edge the stall count reaches the limit.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        starve_next     = starve_reg;
        if (grant == GRANT_WB1) begin
            starve_cnt_next = '0;
            starve_next     = 1'b0;
        end else if (!wb1_valid) begin
            starve_cnt_next = '0;
        end else begin
            if (starve_cnt_reg < LIMIT) begin
                starve_cnt_next = starve_cnt_reg + 4'd1;
            end
            if (starve_cnt_next == LIMIT) begin
                starve_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            starve_reg     <= 1'b0;
            starve_cnt_reg <= '0;
        end else begin
            starve_reg     <= starve_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            we_reg    <= 1'b0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else begin
            case (grant)
                GRANT_WB0: begin
                    we_reg    <= (wb0_rd != '0);
                    waddr_reg <= wb0_rd;
                    wdata_reg <= wb0_data;
                end
                GRANT_WB1: begin
                    we_reg    <= (wb1_rd != '0);
                    waddr_reg <= wb1_rd;
                    wdata_reg <= wb1_data;
                end
                default: begin
                    we_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rf_we    = we_reg;
    assign rf_waddr = waddr_reg;
    assign rf_wdata = wdata_reg;

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .areset   (areset),
        .set_en   (iss_valid && !iss_busy),
        .set_addr (iss_rd),
        .clr_en   (grant == GRANT_WB1),
        .clr_addr (wb1_rd),
        .look_a   (rs1),
        .look_b   (rs2),
        .iss_addr (iss_rd),
        .busy_a   (busy_1),
        .busy_b   (busy_2),
        .iss_busy (iss_busy)
    );

    assign iss_ready = !iss_busy;

`ifdef RF_ARB_BYPASS_EN
    assign byp1_hit = we_reg && addr_hit(rs1, waddr_reg);
    assign byp2_hit = we_reg && addr_hit(rs2, waddr_reg);
    assign byp_data = wdata_reg;
    assign hazard   = busy_1 || busy_2;
`else
    // The registered write is not yet in the register file, so it still counts as pending.
    assign hazard = busy_1 || busy_2
                 || (we_reg && addr_hit(rs1, waddr_reg))
                 || (we_reg && addr_hit(rs2, waddr_reg));
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters. Requester 0 is the core writeback path and has default priority. Requester 1 is a long-latency unit such as a divider or load unit.
- Keeps a 32-bit busy scoreboard of destinations issued to the long-latency unit, and flags read-after-write hazards for the two read addresses.
- Sits between the execute/writeback stages and the register file; drives the register file's write port directly.

Parameters:
- XLEN, 32, data width of the write port.
- STARVE_LIMIT, 4, consecutive stalled cycles of requester 1 before it is forced to win arbitration (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- areset  in  1  synchronous reset, active-low.
- wb0_valid  in  1  core writeback request.
- wb0_ready  out  1  core writeback accepted this cycle.
- wb0_rd  in  5  core destination register.
- wb0_data  in  XLEN  core write data.
- wb1_valid  in  1  long-latency unit writeback request.
- wb1_ready  out  1  long-latency writeback accepted this cycle.
- wb1_rd  in  5  long-latency destination register.
- wb1_data  in  XLEN  long-latency write data.
- iss_valid  in  1  an instruction is issued to the long-latency unit.
- iss_rd  in  5  destination of the issued instruction.
- iss_ready  out  1  issue permitted; 0 when iss_rd is already busy.
- rs1, rs2  in  5 each  read addresses to check for hazards.
- hazard  out  1  rs1 or rs2 depends on a write that is not yet visible in the register file.
- rf_we  out  1  to register file WE3.
- rf_waddr  out  5  to register file A3.
- rf_wdata  out  XLEN  to register file WD3.

Behaviour:
- Reset: when areset=0 at a clk edge, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, starve counter=0 and starve flag=0. Reset has priority over every other event. A request in flight during reset is dropped.
- Handshake: a transfer occurs on a cycle where valid && ready. Ready is combinational from state and the valids only; it never depends on data.
- Arbitration when starve=0:
  - wb0_ready=1.
  - wb1_ready = !wb0_valid.
- Arbitration when starve=1:
  - wb1_ready=1.
  - wb0_ready = !wb1_valid.
- At most one transfer occurs per cycle.
- Starve counter:
  - Increments each cycle that wb1_valid && !wb1_ready, saturating at STARVE_LIMIT.
  - Reaching STARVE_LIMIT sets starve at the next edge.
  - A wb1 transfer clears both counter and starve.
  - wb1_valid=0 clears the counter.
- Write port output:
  - An accepted transfer is registered; rf_we/rf_waddr/rf_wdata are valid in the following cycle. The register file therefore commits at the second edge after acceptance (latency 2 edges).
  - rf_we deasserts in any cycle after a no-transfer cycle.
  - rd=0 transfers are accepted but produce rf_we=0.
- Scoreboard:
  - iss_valid && iss_ready && iss_rd!=0 sets busy[iss_rd].
  - A wb1 transfer clears busy[wb1_rd].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - iss_ready = !busy[iss_rd]. x0 is never busy.
- Hazard: hazard = H(rs1) | H(rs2), where H(r) = r!=0 && (busy[r] || (rf_we && rf_waddr==r)).
- wb1 transfer to a non-busy register: the write is performed and the scoreboard is unchanged.

Optional Feature:
- Macro RF_ARB_BYPASS_EN.
- When defined:
  - Adds outputs byp1_hit (1 bit), byp2_hit (1 bit) and byp_data (XLEN).
  - bypN_hit = rsN!=0 && rf_we && rf_waddr==rsN; byp_data = rf_wdata.
  - The rf_we term is removed from H(r), so only busy registers raise hazard.
- When undefined: the ports are absent and hazard behaves as specified above.

Decomposition:
- Package rf_arb_pkg holds:
  - constants XLEN_DEF=32, REG_AW=5, NUM_REGS=32;
  - typedef reg_addr_t (5 bits);
  - typedef wb_req_t {valid, rd, data}.
- One sub-module, rf_scoreboard: 32-bit busy vector with set/clear ports, set-wins rule, x0 masking, and two combinational lookup ports plus an issue lookup port.

Test Plan:
- Reset: hold areset=0 for 2 cycles with both valids=1 -> rf_we=0, busy=0, iss_ready=1, no transfer; the first transfer after release appears on rf_* one cycle later.
- Priority: wb0 (rd=5, 0xA5A5A5A5) and wb1 (rd=6) both valid -> wb0_ready=1, wb1_ready=0; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5.
- Starvation: wb0_valid held 1 and wb1_valid held 1 with STARVE_LIMIT=4 -> wb1 is granted on cycle 5, wb0_ready=0 that cycle, then priority returns to wb0.
- Scoreboard: issue rd=7, then rs1=7 -> hazard=1 and issue of rd=7 gives iss_ready=0. wb1 transfer rd=7 -> hazard=1 for one more cycle (rf_we in flight), then 0.
- Same-cycle set and clear: wb1 transfer rd=9 and iss rd=9 in the same cycle -> busy[9] remains 1. Transfer with rd=0 -> rf_we=0 and no hazard for rs=0.
- Bypass build: with RF_ARB_BYPASS_EN defined, repeat the scoreboard case -> in the rf_we cycle byp1_hit=1, byp_data equals the written data, and hazard=0.
